// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared CPU constants and fetch-entry type                |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue : DEPTH-entry circular buffer of fetch entries         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [2:0]   count,
  output logic         full,
  output logic         empty
);

  localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [2:0]       C_DEPTH = 3'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [2:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == 3'd0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 3'd0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : PC sequencing, stall buffering and branch redirect    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        misalign_err
);

  localparam logic [2:0] C_DEPTH = 3'(FQ_DEPTH);

  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  fetch_entry_t w_fetch;
  fetch_entry_t w_head;
  fetch_entry_t w_ifid_next;
  logic [2:0]   w_count;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_clear;
  logic         w_ifid_load;

  assign imem_addr = r_pc;
  assign w_fetch   = '{pc: r_pc, instr: imem_data};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (w_clear),
    .push_data (w_fetch),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    w_ifid_load = 1'b0;
    w_ifid_next = w_fetch;
    w_pc_next   = r_pc;
    if (branch_taken) begin
      w_clear   = 1'b1;
      w_pc_next = {branch_target[31:2], 2'b00};
    end else if (!stall) begin
      // Buffered words are older than the current fetch, so they go first.
      w_ifid_load = 1'b1;
      w_pc_next   = r_pc + 32'd4;
      if (!w_empty) begin
        w_ifid_next = w_head;
        w_pop       = 1'b1;
        w_push      = 1'b1;
      end
    end else if (w_count < C_DEPTH) begin
      w_push    = 1'b1;
      w_pc_next = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      ifid_pc      <= 32'h0000_0000;
      ifid_instr   <= NOP_INSTR;
      ifid_valid   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      misalign_err <= branch_taken && (branch_target[1:0] != 2'b00);
      if (branch_taken) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else if (w_ifid_load) begin
        ifid_pc    <= w_ifid_next.pc;
        ifid_instr <= w_ifid_next.instr;
        ifid_valid <= 1'b1;
      end
    end
  end

  // Full flag is only informational here; count drives the stall decision.
  logic w_unused;
  assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit : directed self-checking bench for fetch_unit        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instruction word encodes its own low address bits.
  assign imem_data = {16'hC0DE, imem_addr[15:0]};

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .misalign_err  (misalign_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    #3;
    check_eq("rst_valid", 32'(ifid_valid), 32'd0);
    check_eq("rst_instr", ifid_instr, 32'h0000_0013);
    check_eq("rst_pc", ifid_pc, 32'h0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    step(); step();
    reset = 1'b0;

    // Straight-line fetch, one-edge latency
    step();
    check_eq("seq0_pc", ifid_pc, 32'h100);
    check_eq("seq0_valid", 32'(ifid_valid), 32'd1);
    check_eq("seq0_instr", ifid_instr, 32'hC0DE_0100);
    step();
    check_eq("seq1_pc", ifid_pc, 32'h104);
    step();
    check_eq("seq2_pc", ifid_pc, 32'h108);
    check_eq("seq2_instr", ifid_instr, 32'hC0DE_0108);

    // Stall 4 cycles: queue takes 0x10C, 0x110, then PC holds at 0x114
    stall = 1'b1;
    step(); check_eq("stl1_pc", ifid_pc, 32'h108); check_eq("stl1_addr", imem_addr, 32'h110);
    step(); check_eq("stl2_addr", imem_addr, 32'h114);
    step(); check_eq("stl3_addr", imem_addr, 32'h114);
    step(); check_eq("stl4_pc", ifid_pc, 32'h108); check_eq("stl4_valid", 32'(ifid_valid), 32'd1);
    check_eq("stl4_addr", imem_addr, 32'h114);
    stall = 1'b0;
    step(); check_eq("rel0_pc", ifid_pc, 32'h10C); check_eq("rel0_instr", ifid_instr, 32'hC0DE_010C);
    step(); check_eq("rel1_pc", ifid_pc, 32'h110);
    step(); check_eq("rel2_pc", ifid_pc, 32'h114);

    // Redirect with a full queue
    branch_taken = 1'b1; branch_target = 32'h20;
    step();
    check_eq("br_valid", 32'(ifid_valid), 32'd0);
    check_eq("br_instr", ifid_instr, 32'h0000_0013);
    check_eq("br_addr", imem_addr, 32'h20);
    branch_taken = 1'b0;
    step(); check_eq("br1_pc", ifid_pc, 32'h20); check_eq("br1_valid", 32'(ifid_valid), 32'd1);
    check_eq("br1_instr", ifid_instr, 32'hC0DE_0020);
    step(); check_eq("br2_pc", ifid_pc, 32'h24);

    // Fill queue, then branch and stall together
    stall = 1'b1;
    step(); step();
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    check_eq("bs_valid", 32'(ifid_valid), 32'd0);
    check_eq("bs_instr", ifid_instr, 32'h0000_0013);
    check_eq("bs_addr", imem_addr, 32'h40);
    branch_taken = 1'b0; stall = 1'b0;
    step(); check_eq("bs1_pc", ifid_pc, 32'h40); check_eq("bs1_valid", 32'(ifid_valid), 32'd1);

    // Misaligned target
    branch_taken = 1'b1; branch_target = 32'h22;
    step();
    check_eq("mis_err", 32'(misalign_err), 32'd1);
    check_eq("mis_addr", imem_addr, 32'h20);
    branch_taken = 1'b0;
    step();
    check_eq("mis_err_clr", 32'(misalign_err), 32'd0);
    check_eq("mis_pc", ifid_pc, 32'h20);

    // PC wraps past the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    step(); check_eq("wrap0_pc", ifid_pc, 32'hFFFF_FFFC);
    step(); check_eq("wrap1_pc", ifid_pc, 32'h0); check_eq("wrap1_instr", ifid_instr, 32'hC0DE_0000);

    // Reset mid-stall with a full queue
    stall = 1'b1;
    step(); step();
    #2 reset = 1'b1;
    #1;
    check_eq("mrst_valid", 32'(ifid_valid), 32'd0);
    check_eq("mrst_instr", ifid_instr, 32'h0000_0013);
    check_eq("mrst_pc", ifid_pc, 32'h0);
    check_eq("mrst_addr", imem_addr, RESET_PC);
    step();
    reset = 1'b0; stall = 1'b0;
    step(); check_eq("post0_pc", ifid_pc, 32'h100); check_eq("post0_valid", 32'(ifid_valid), 32'd1);
    step(); check_eq("post1_pc", ifid_pc, 32'h104);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, fetch-queue entry count (range 1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port imem_addr, output, 32, byte address to instruction memory; equals PC combinationally.
REQ-006 SHALL have port imem_data, input, 32, instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port stall, input, 1, decode-stage hold request from the hazard unit.
REQ-008 SHALL have port branch_taken, input, 1, redirect request from the branch-resolution stage.
REQ-009 SHALL have port branch_target, input, 32, redirect byte address.
REQ-010 SHALL have port ifid_pc, output, 32, PC of the instruction presented to decode.
REQ-011 SHALL have port ifid_instr, output, 32, instruction presented to decode.
REQ-012 SHALL have port ifid_valid, output, 1, ifid_instr is a real instruction, not a bubble.
REQ-013 SHALL have port misalign_err, output, 1, one-cycle pulse when branch_target[1:0] != 0.

Function
REQ-014 SHALL fetch at most one word per cycle: fetch word = {PC, imem_data}.
REQ-015 SHALL increment PC by 4 on every accepted fetch; PC wraps modulo 2^32 without error.
REQ-016 SHALL, when stall=0 and branch_taken=0, load ifid from queue head if count>0, else from the fetch word; set ifid_valid=1; accept the fetch.
REQ-017 SHALL, in that case with count>0, pop the head and push the fetch word in the same cycle, count unchanged.
REQ-018 SHALL, when stall=1 and branch_taken=0, hold ifid_pc/ifid_instr/ifid_valid unchanged.
REQ-019 SHALL, while stalled with count<FQ_DEPTH, push the fetch word, increment count and advance PC.
REQ-020 SHALL, while stalled with count==FQ_DEPTH, hold PC and discard the fetch word.
REQ-021 SHALL give branch_taken priority over stall.
REQ-022 SHALL, on branch_taken, clear the queue, discard the fetch word, set PC <= {branch_target[31:2],2'b00}, ifid_valid <= 0 and ifid_instr <= NOP 32'h0000_0013; ifid_pc is don't-care.
REQ-023 SHALL pulse misalign_err for the cycle after a branch_taken whose target[1:0] != 0; the redirect still proceeds, aligned.
REQ-024 SHALL present the first instruction after a redirect on ifid at the second rising edge after branch_taken, i.e. a one-cycle bubble.
REQ-025 SHALL have one-edge latency: the word at PC in cycle N reaches ifid at edge N+1 when not stalled and the queue is empty.
REQ-026 SHALL preserve program order: ifid_pc sequence is strictly PC-ordered between redirects.

Reset
REQ-027 SHALL, on reset assertion and independent of clk, set PC=RESET_PC, queue count=0, ifid_valid=0, ifid_instr=NOP, ifid_pc=0, misalign_err=0.
REQ-028 SHALL, after reset deassertion, present the instruction at RESET_PC on ifid at the first rising edge with stall=0.
REQ-029 SHALL discard all queued and in-flight words when reset is asserted mid-operation, including mid-stall or mid-redirect.

Structure
REQ-030 SHALL take the NOP encoding, the default RESET_PC and the {pc, instr} fetch-entry type from the shared cpu package.
REQ-031 SHALL implement the queue as sub-module fetch_queue: FQ_DEPTH-entry circular buffer with push, pop, clear, count, head outputs, with simultaneous push/pop allowed when full.

Verification
REQ-032 SHALL cover: reset, stall=0, memory words at 0,4,8 -> ifid_pc 0,4,8 on edges 1,2,3, ifid_valid=1 throughout.
REQ-033 SHALL cover: stall high 4 cycles from ifid_pc=4 -> ifid holds 4; PC advances to 16 and then holds; queue holds 8,12; after release ifid_pc = 8, 12, 16.
REQ-034 SHALL cover: branch_taken with target 0x20 while count=2 -> next edge ifid_valid=0 with ifid_instr=0x13; following edge ifid_pc=0x20.
REQ-035 SHALL cover: branch_taken and stall in the same cycle -> redirect wins, same response as REQ-034.
REQ-036 SHALL cover: branch_target 0x22 -> misalign_err pulses 1 cycle and ifid_pc=0x20.
REQ-037 SHALL cover: reset asserted mid-stall with count=2 -> outputs go to reset values immediately; the first post-reset ifid_pc equals RESET_PC.
